// File: rtl/fa_serial_adder_if.sv
// Operand/result bundle for the serial add/subtract engine.
// Latency: none, wires only.
// Backpressure: none; start is only honoured while the engine is not busy.
interface fa_serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;

    modport master (
        output start, sub, a, b, ci,
        input  busy, done, s, co, ovf
    );

    modport slave (
        input  start, sub, a, b, ci,
        output busy, done, s, co, ovf
    );
endinterface

// File: rtl/fa_serial_adder.sv
// Add/subtract of two WIDTH-bit operands using one SLICE-bit adder reused each cycle.
// Latency: N=WIDTH/SLICE run cycles; done pulses one cycle after the N-th slice edge.
// Backpressure: start is ignored while busy; a new start in the done cycle chains directly.
module fa_serial_adder #(
    parameter int WIDTH = 8,
    parameter int SLICE = 1
) (
    input  logic               clk,
    input  logic               rst,
    fa_serial_adder_if.slave   bus
);
    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 2 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_params
            $error("fa_serial_adder: WIDTH must be >= 2 and a multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             accept;
    logic             last_slice;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             carry_q;
    logic             sub_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH-1:0] s_q;
    logic             co_q;
    logic             ovf_q;

    logic [SLICE:0]   slice_sum;
    logic [WIDTH-1:0] sum_ext;
    logic [WIDTH-1:0] res_next;
    logic             msb_cin;

    // The one physical adder: SLICE bits plus the running carry.
    assign slice_sum = {1'b0, a_q[SLICE-1:0]} + {1'b0, b_q[SLICE-1:0]} + {{SLICE{1'b0}}, carry_q};

    // New slice enters at the MSB end so the first slice lands at bit 0 after N shifts.
    assign sum_ext  = WIDTH'(slice_sum[SLICE-1:0]);
    assign res_next = (res_q >> SLICE) | (sum_ext << (WIDTH - SLICE));

    // Carry into bit WIDTH-1 recovered from the sum bit: s = a ^ b ^ cin.
    assign msb_cin = a_q[SLICE-1] ^ b_q[SLICE-1] ^ slice_sum[SLICE-1];

    assign last_slice = (cnt_q == CW'(N - 1));

    // State register; reset returns to IDLE and aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: accept start only when idle or in the done cycle.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_slice) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: capture operands on accept (subtract as a + ~b + ~ci), then shift one slice per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_q     <= bus.a;
            b_q     <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.sub ? ~bus.ci : bus.ci;
            sub_q   <= bus.sub;
            cnt_q   <= '0;
        end else if (state_q == RUN) begin
            a_q     <= a_q >> SLICE;
            b_q     <= b_q >> SLICE;
            res_q   <= res_next;
            carry_q <= slice_sum[SLICE];
            cnt_q   <= cnt_q + 1'b1;
            if (last_slice) begin
                s_q   <= res_next;
                co_q  <= sub_q ^ slice_sum[SLICE];
                ovf_q <= msb_cin ^ slice_sum[SLICE];
            end
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.s    = s_q;
    assign bus.co   = co_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_fa_serial_adder.sv
// Bench for three engine configurations (8x1, 8x4, 4x2) sharing one stimulus stream.
// Latency: checks done timing and throughput against an arithmetic timeline model.
// Backpressure: start pulses during RUN must be dropped, never queued.
module tb_fa_serial_adder;
    localparam int NI = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       sub;
    logic       ci;
    logic [7:0] a;
    logic [7:0] b;
    logic       hold;
    logic       chk_en;

    always #5 clk = ~clk;

    fa_serial_adder_if #(.WIDTH(8)) if8a ();
    fa_serial_adder_if #(.WIDTH(8)) if8b ();
    fa_serial_adder_if #(.WIDTH(4)) if4  ();

    assign if8a.start = start; assign if8a.sub = sub; assign if8a.ci = ci;
    assign if8a.a = a;         assign if8a.b = b;
    assign if8b.start = start; assign if8b.sub = sub; assign if8b.ci = ci;
    assign if8b.a = a;         assign if8b.b = b;
    assign if4.start  = start; assign if4.sub  = sub; assign if4.ci  = ci;
    assign if4.a = a[3:0];     assign if4.b = b[3:0];

    fa_serial_adder #(.WIDTH(8), .SLICE(1)) u8s1 (.clk(clk), .rst(rst), .bus(if8a));
    fa_serial_adder #(.WIDTH(8), .SLICE(4)) u8s4 (.clk(clk), .rst(rst), .bus(if8b));
    fa_serial_adder #(.WIDTH(4), .SLICE(2)) u4s2 (.clk(clk), .rst(rst), .bus(if4));

    // Per-instance view of the outputs, index 0=8x1, 1=8x4, 2=4x2.
    logic [NI-1:0] o_busy, o_done, o_co, o_ovf;
    logic [7:0]    o_s [NI];
    assign o_busy = {if4.busy, if8b.busy, if8a.busy};
    assign o_done = {if4.done, if8b.done, if8a.done};
    assign o_co   = {if4.co,   if8b.co,   if8a.co};
    assign o_ovf  = {if4.ovf,  if8b.ovf,  if8a.ovf};
    assign o_s[0] = if8a.s;
    assign o_s[1] = if8b.s;
    assign o_s[2] = {4'h0, if4.s};

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int w_of(input int i);
        return (i == 2) ? 4 : 8;
    endfunction

    function automatic int n_of(input int i);
        return (i == 0) ? 8 : 2;
    endfunction

    // Plain integer arithmetic: result, carry/borrow and signed range check.
    function automatic void ref_op(input int w, input int av, input int bv, input int civ,
                                   input int subv, output int rs, output int rco, output int rovf);
        longint m, ua, ub, r, sa, sb, sr;
        m  = longint'(1) << w;
        ua = longint'(av) % m;
        ub = longint'(bv) % m;
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        if (subv == 0) begin
            r   = ua + ub + civ;
            rco = (r >= m) ? 1 : 0;
            sr  = sa + sb + civ;
        end else begin
            r   = ua - ub - civ;
            rco = (r < 0) ? 1 : 0;
            sr  = sa - sb - civ;
        end
        rs   = int'((r + m) % m);
        rovf = (sr < -(m / 2) || sr > (m / 2) - 1) ? 1 : 0;
    endfunction

    // Timeline model: st 0=idle, 1..N=running cycle, N+1=done cycle.
    int st [NI] = '{0, 0, 0};
    int ps [NI], pc [NI], po [NI];
    int es [NI], ec [NI], eo [NI];
    bit vld [NI];

    // Model update from the inputs seen at each rising edge.
    always @(posedge clk) begin : model
        int rs, rc, ro, n, msk;
        for (int i = 0; i < NI; i++) begin
            n   = n_of(i);
            msk = (1 << w_of(i)) - 1;
            if (rst) begin
                st[i] <= 0; es[i] <= 0; ec[i] <= 0; eo[i] <= 0; vld[i] <= 1'b1;
            end else if ((st[i] == 0 || st[i] == n + 1) && start) begin
                ref_op(w_of(i), int'(a) & msk, int'(b) & msk, int'(ci), int'(sub), rs, rc, ro);
                ps[i] <= rs; pc[i] <= rc; po[i] <= ro;
                st[i] <= 1; vld[i] <= 1'b0;
            end else if (st[i] >= 1 && st[i] < n) begin
                st[i] <= st[i] + 1;
            end else if (st[i] == n) begin
                st[i] <= n + 1;
                es[i] <= ps[i]; ec[i] <= pc[i]; eo[i] <= po[i]; vld[i] <= 1'b1;
            end else if (st[i] == n + 1) begin
                st[i] <= 0;
            end
        end
    end

    int cyc = 0;
    int last_done [NI];

    // Every-cycle compare of all three instances, plus throughput while start is held.
    always @(negedge clk) begin
        cyc++;
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                check($sformatf("inst%0d busy", i), 32'(o_busy[i]),
                      32'(st[i] >= 1 && st[i] <= n_of(i)));
                check($sformatf("inst%0d done", i), 32'(o_done[i]), 32'(st[i] == n_of(i) + 1));
                if (vld[i]) begin
                    check($sformatf("inst%0d s", i),   32'(o_s[i]), 32'(es[i]));
                    check($sformatf("inst%0d co", i),  32'(o_co[i]), 32'(ec[i]));
                    check($sformatf("inst%0d ovf", i), 32'(o_ovf[i]), 32'(eo[i]));
                end
                if (hold) begin
                    if (o_done[i]) begin
                        if (last_done[i] >= 0)
                            check($sformatf("inst%0d period", i), 32'(cyc - last_done[i]),
                                  32'(n_of(i) + 1));
                        last_done[i] = cyc;
                    end
                end else begin
                    last_done[i] = -1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One 8x1 operation with hand-computed expectations, latency and busy length.
    task automatic run8(input string nm, input logic [7:0] av, input logic [7:0] bv,
                        input logic civ, input logic subv, input logic [7:0] exs,
                        input logic exco, input logic exovf);
        int lat, bcnt;
        bit got;
        a = av; b = bv; ci = civ; sub = subv; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1; bcnt = 0; got = 1'b0;
        while (!got && lat < 40) begin
            if (if8a.busy) bcnt++;
            tick();
            lat++;
            if (if8a.done) got = 1'b1;
        end
        if (!got) check({nm, " timeout"}, 32'd0, 32'd1);
        check({nm, " latency"}, 32'(lat), 32'd9);
        check({nm, " busy cycles"}, 32'(bcnt), 32'd8);
        check({nm, " s"}, 32'(if8a.s), 32'(exs));
        check({nm, " co"}, 32'(if8a.co), 32'(exco));
        check({nm, " ovf"}, 32'(if8a.ovf), 32'(exovf));
        tick();
    endtask

    initial begin
        int rs, rc, ro, dcnt;
        rst = 1'b1; start = 1'b0; sub = 1'b0; ci = 1'b0; a = '0; b = '0;
        hold = 1'b0; chk_en = 1'b0;
        tick();
        tick();
        chk_en = 1'b1;
        check("reset busy", 32'(if8a.busy), 32'd0);
        check("reset done", 32'(if8a.done), 32'd0);
        check("reset s",    32'(if8a.s),    32'd0);
        check("reset co",   32'(if8a.co),   32'd0);
        check("reset ovf",  32'(if8a.ovf),  32'd0);
        rst = 1'b0;

        // Pin the reference arithmetic itself.
        ref_op(8, 'h7F, 'h01, 0, 0, rs, rc, ro);
        check("model 7F+01 s", 32'(rs), 32'h80);
        check("model 7F+01 ovf", 32'(ro), 32'd1);
        ref_op(4, 'h3, 'h5, 1, 1, rs, rc, ro);
        check("model 3-5-1 s", 32'(rs), 32'hD);
        check("model 3-5-1 co", 32'(rc), 32'd1);

        tick();
        run8("add 7F+01",    8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        run8("add FF+01+1",  8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
        run8("sub 05-07",    8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b1, 1'b0);
        run8("sub 80-01",    8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1);

        // Second start three cycles into RUN must be dropped.
        a = 8'h12; b = 8'h34; ci = 1'b0; sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        a = 8'hFF; start = 1'b1;
        tick();
        start = 1'b0;
        dcnt = 0;
        for (int k = 0; k < 14; k++) begin
            tick();
            if (if8a.done) dcnt++;
        end
        check("ignore done count", 32'(dcnt), 32'd1);
        check("ignore s", 32'(if8a.s), 32'h46);

        // Reset on the fourth RUN cycle aborts with cleared outputs.
        a = 8'h55; b = 8'h22; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort busy", 32'(if8a.busy), 32'd0);
        check("abort done", 32'(if8a.done), 32'd0);
        check("abort s",    32'(if8a.s),    32'd0);
        check("abort co",   32'(if8a.co),   32'd0);
        check("abort ovf",  32'(if8a.ovf),  32'd0);
        for (int k = 0; k < 12; k++) begin
            tick();
            if (if8a.done) check("abort stray done", 32'd1, 32'd0);
        end

        // Random traffic including occasional resets and mid-run starts.
        for (int k = 0; k < 400; k++) begin
            start = ($urandom_range(2) == 0);
            a     = 8'($urandom);
            b     = 8'($urandom);
            ci    = 1'($urandom);
            sub   = 1'($urandom);
            rst   = ($urandom_range(59) == 0);
            tick();
        end
        rst = 1'b0; start = 1'b0;
        for (int k = 0; k < 12; k++) tick();

        // start held high; each 4-bit combination held for one 4x2 period.
        hold = 1'b1;
        start = 1'b1;
        for (int sv = 0; sv < 2; sv++)
            for (int cv = 0; cv < 2; cv++)
                for (int av = 0; av < 16; av++)
                    for (int bv = 0; bv < 16; bv++) begin
                        sub = 1'(sv);
                        ci  = 1'(cv);
                        a   = {4'($urandom), 4'(av)};
                        b   = {4'($urandom), 4'(bv)};
                        tick();
                        tick();
                        tick();
                    end
        hold = 1'b0;
        start = 1'b0;
        for (int k = 0; k < 12; k++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
